irq_ctrl: RTL and testbench



---
 rtl/irq_pkg.sv | 27 ++
 rtl/irq_prio_enc.sv | 18 +
 rtl/irq_ctrl.sv | 169 ++++++++++++++++
 tb/tb_irq_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// Shared constants, bus payload and FSM encoding for the irq_ctrl interrupt controller.
package irq_pkg;

   localparam int unsigned IDW = 5;
   localparam int unsigned DW  = 32;
   localparam int unsigned AW  = 32;

   localparam logic [AW-1:0] IRQ_MASK     = 32'hffff_0040;
   localparam logic [AW-1:0] REG_PEND     = 32'h0000_0000;
   localparam logic [AW-1:0] REG_ENABLE   = 32'h0000_0004;
   localparam logic [AW-1:0] REG_TYPE     = 32'h0000_0008;
   localparam logic [AW-1:0] REG_CLAIM    = 32'h0000_000c;
   localparam logic [AW-1:0] REG_COMPLETE = 32'h0000_0010;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      SERVICE = 2'd2
   } irq_state_e;

   typedef struct packed {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } bus_req_t;

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index priority encoder: returns index+1 of the first set request bit, 0 if none.
module irq_prio_enc #(
   parameter int unsigned N = 8,
   parameter int unsigned W = 5
) (
   input  logic [N-1:0] req_i,
   output logic [W-1:0] id_c_o
);

   // Scan from the top so the lowest set bit is the last to write.
   always_comb begin
      id_c_o = '0;
      for (int i = int'(N) - 1; i >= 0; i--) begin
         if (req_i[i]) id_c_o = W'(i + 1);
      end
   end

endmodule

// File: rtl/irq_ctrl.sv
// Memory-mapped interrupt controller: latches/masks NSRC sources, raises one request to the
// core and runs a claim/complete handshake over the shared peripheral bus.
module irq_ctrl
   import irq_pkg::*;
#(
   parameter int unsigned NSRC = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            mem_we,
   input  logic [AW-1:0]   mem_addr,
   inout  wire  [DW-1:0]   mem_data,
   input  logic [NSRC-1:0] irq_src,
   output logic            irq_out,
   output logic [IDW-1:0]  irq_id
);

   bus_req_t        bus_c;
   logic            hit_pend_c, hit_en_c, hit_type_c, hit_claim_c, hit_cmpl_c, hit_any_c;
   logic            wr_pend_c, wr_en_c, wr_type_c, wr_claim_c, wr_cmpl_c;
   logic [IDW-1:0]  wdata_id_c;
   logic [NSRC-1:0] wdata_src_c;
   logic            unused_data_c;

   logic [NSRC-1:0] src_q, pend_q, pend_d, enable_q, enable_d, type_q, type_d;
   irq_state_e      state_q, state_d;
   logic            irq_out_q, irq_out_d;
   logic [IDW-1:0]  irq_id_q, irq_id_d, svc_id_q, svc_id_d;
   logic [IDW-1:0]  best_id_c;
   logic            claim_ok_c, cmpl_ok_c;
   logic [DW-1:0]   rd_data_c;
   logic            rd_en_c;

   assign bus_c = '{we: mem_we, addr: mem_addr, data: mem_data};

   // Exact-match address decode on the shared bus.
   assign hit_pend_c  = bus_c.addr == (IRQ_MASK | REG_PEND);
   assign hit_en_c    = bus_c.addr == (IRQ_MASK | REG_ENABLE);
   assign hit_type_c  = bus_c.addr == (IRQ_MASK | REG_TYPE);
   assign hit_claim_c = bus_c.addr == (IRQ_MASK | REG_CLAIM);
   assign hit_cmpl_c  = bus_c.addr == (IRQ_MASK | REG_COMPLETE);
   assign hit_any_c   = hit_pend_c | hit_en_c | hit_type_c | hit_claim_c | hit_cmpl_c;

   assign wr_pend_c  = bus_c.we & hit_pend_c;
   assign wr_en_c    = bus_c.we & hit_en_c;
   assign wr_type_c  = bus_c.we & hit_type_c;
   assign wr_claim_c = bus_c.we & hit_claim_c;
   assign wr_cmpl_c  = bus_c.we & hit_cmpl_c;

   assign wdata_id_c    = bus_c.data[IDW-1:0];
   assign wdata_src_c   = bus_c.data[NSRC-1:0];
   assign unused_data_c = ^bus_c.data;

   assign claim_ok_c = wr_claim_c && (state_q == REQ) && (wdata_id_c == irq_id_q);
   assign cmpl_ok_c  = wr_cmpl_c && (state_q == SERVICE) && (wdata_id_c == svc_id_q);

   irq_prio_enc #(
      .N (NSRC),
      .W (IDW)
   ) u_prio_enc (
      .req_i  (pend_q & enable_q),
      .id_c_o (best_id_c)
   );

   assign enable_d = wr_en_c   ? wdata_src_c : enable_q;
   assign type_d   = wr_type_c ? wdata_src_c : type_q;

   // Edge bits: set on a rising edge, cleared by W1C or claim, set wins.
   // Level bits: follow the line unless that source is (about to be) in service.
   always_comb begin
      pend_d = pend_q;
      for (int i = 0; i < int'(NSRC); i++) begin
         if (type_q[i]) begin
            if (wr_pend_c && wdata_src_c[i]) pend_d[i] = 1'b0;
            if (claim_ok_c && (irq_id_q == IDW'(i + 1))) pend_d[i] = 1'b0;
            if (irq_src[i] && !src_q[i]) pend_d[i] = 1'b1;
         end else begin
            pend_d[i] = irq_src[i] && (svc_id_d != IDW'(i + 1));
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (best_id_c != '0) state_d = REQ;
         REQ: begin
            if (claim_ok_c)            state_d = SERVICE;
            else if (best_id_c == '0)  state_d = IDLE;
         end
         SERVICE: if (cmpl_ok_c) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Next values of the registered request, id and in-service id.
   always_comb begin
      irq_out_d = 1'b0;
      irq_id_d  = irq_id_q;
      svc_id_d  = svc_id_q;
      case (state_q)
         IDLE: begin
            irq_id_d  = best_id_c;
            irq_out_d = best_id_c != '0;
         end
         REQ: begin
            if (claim_ok_c) begin
               svc_id_d = irq_id_q;
            end else begin
               irq_id_d  = best_id_c;
               irq_out_d = best_id_c != '0;
            end
         end
         SERVICE: begin
            if (cmpl_ok_c) begin
               svc_id_d = '0;
               irq_id_d = '0;
            end
         end
         default: begin
            irq_id_d = '0;
            svc_id_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         src_q     <= '0;
         pend_q    <= '0;
         enable_q  <= '0;
         type_q    <= '0;
         irq_out_q <= 1'b0;
         irq_id_q  <= '0;
         svc_id_q  <= '0;
      end else begin
         src_q     <= irq_src;
         pend_q    <= pend_d;
         enable_q  <= enable_d;
         type_q    <= type_d;
         irq_out_q <= irq_out_d;
         irq_id_q  <= irq_id_d;
         svc_id_q  <= svc_id_d;
      end
   end

   assign irq_out = irq_out_q;
   assign irq_id  = irq_id_q;

   // Side-effect-free read mux; unstored bits read as zero.
   always_comb begin
      rd_data_c = '0;
      if (hit_pend_c)  rd_data_c = DW'(pend_q);
      if (hit_en_c)    rd_data_c = DW'(enable_q);
      if (hit_type_c)  rd_data_c = DW'(type_q);
      if (hit_claim_c) rd_data_c = DW'(best_id_c);
      if (hit_cmpl_c)  rd_data_c = DW'(svc_id_q);
   end

   // Only drive the shared bus for our own addresses.
   assign rd_en_c  = rst && !bus_c.we && hit_any_c;
   assign mem_data = rd_en_c ? rd_data_c : {DW{1'bz}};

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed scenario bench for irq_ctrl with a queue of expected bus read values.
`timescale 1ns/1ps
module tb_irq_ctrl;
   import irq_pkg::*;

   localparam int unsigned NSRC = 8;
   localparam logic [31:0] A_PEND    = 32'hffff_0040;
   localparam logic [31:0] A_EN      = 32'hffff_0044;
   localparam logic [31:0] A_TYPE    = 32'hffff_0048;
   localparam logic [31:0] A_CLAIM   = 32'hffff_004c;
   localparam logic [31:0] A_CMPL    = 32'hffff_0050;
   localparam logic [31:0] A_FOREIGN = 32'hffff_0030;
   localparam logic [31:0] A_IDLE    = 32'h0000_1000;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            mem_we = 1'b0;
   logic [31:0]     mem_addr = A_IDLE;
   logic [31:0]     bus_drv = '0;
   logic            bus_oe = 1'b0;
   logic [NSRC-1:0] irq_src = '0;
   logic            irq_out;
   logic [IDW-1:0]  irq_id;
   wire  [31:0]     mem_data;

   int checks = 0;
   int failures = 0;
   logic [31:0] exp_q[$];

   // Undriven bus idles high, so any stray driver shows up as zeros.
   pullup (mem_data);
   assign mem_data = bus_oe ? bus_drv : {32{1'bz}};

   always #5 clk = ~clk;

   irq_ctrl #(.NSRC(NSRC)) dut (
      .clk      (clk),
      .rst      (rst),
      .mem_we   (mem_we),
      .mem_addr (mem_addr),
      .mem_data (mem_data),
      .irq_src  (irq_src),
      .irq_out  (irq_out),
      .irq_id   (irq_id)
   );

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      mem_addr = a; bus_drv = d; bus_oe = 1'b1; mem_we = 1'b1;
      @(negedge clk);
      mem_we = 1'b0; bus_oe = 1'b0; mem_addr = A_IDLE;
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] d);
      mem_addr = a;
      #1 d = mem_data;
      mem_addr = A_IDLE;
      #1;
   endtask

   task automatic test_reset();
      logic [31:0] got, exp;
      logic [31:0] addrs [6];
      rst = 1'b0; irq_src = '0;
      tick(); tick();
      rst = 1'b1;
      checks++;
      if (irq_out !== 1'b0 || irq_id !== 5'd0) begin
         failures++; $display("FAIL reset_outputs irq_out=%0b irq_id=%0d exp 0/0", irq_out, irq_id);
      end
      addrs = '{A_PEND, A_EN, A_TYPE, A_CLAIM, A_CMPL, A_FOREIGN};
      for (int k = 0; k < 5; k++) exp_q.push_back(32'h0);
      exp_q.push_back(32'hffff_ffff);
      foreach (addrs[k]) begin
         rd(addrs[k], got);
         exp = exp_q.pop_front();
         checks++;
         if (got !== exp) begin
            failures++; $display("FAIL reset_read addr=%h got=%h exp=%h", addrs[k], got, exp);
         end
      end
   endtask

   task automatic test_edge_claim();
      logic [31:0] got, exp;
      wr(A_TYPE, 32'h1); wr(A_EN, 32'h1);
      irq_src[0] = 1'b1; tick();
      checks++;
      if (irq_out !== 1'b0) begin
         failures++; $display("FAIL edge_early irq_out=%0b exp 0", irq_out);
      end
      irq_src[0] = 1'b0; tick();
      checks++;
      if (irq_out !== 1'b1 || irq_id !== 5'd1) begin
         failures++; $display("FAIL edge_latency irq_out=%0b irq_id=%0d exp 1/1", irq_out, irq_id);
      end
      exp_q.push_back(32'h1); exp_q.push_back(32'h1);
      rd(A_PEND, got); exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin failures++; $display("FAIL edge_pend got=%h exp=%h", got, exp); end
      rd(A_CLAIM, got); exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin failures++; $display("FAIL edge_claim_rd got=%h exp=%h", got, exp); end
      wr(A_CLAIM, 32'h1);
      checks++;
      if (irq_out !== 1'b0 || irq_id !== 5'd1) begin
         failures++; $display("FAIL edge_claimed irq_out=%0b irq_id=%0d exp 0/1", irq_out, irq_id);
      end
      exp_q.push_back(32'h0); exp_q.push_back(32'h1);
      rd(A_PEND, got); exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin failures++; $display("FAIL edge_pend_clr got=%h exp=%h", got, exp); end
      rd(A_CMPL, got); exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin failures++; $display("FAIL edge_svc_id got=%h exp=%h", got, exp); end
      wr(A_CMPL, 32'h1);
      tick(); tick();
      checks++;
      if (irq_out !== 1'b0 || irq_id !== 5'd0) begin
         failures++; $display("FAIL edge_complete irq_out=%0b irq_id=%0d exp 0/0", irq_out, irq_id);
      end
   endtask

   task automatic test_level();
      logic [31:0] got, exp;
      wr(A_TYPE, 32'h0); wr(A_EN, 32'h6);
      irq_src[2:1] = 2'b11; tick(); tick();
      checks++;
      if (irq_out !== 1'b1 || irq_id !== 5'd2) begin
         failures++; $display("FAIL level_req irq_out=%0b irq_id=%0d exp 1/2", irq_out, irq_id);
      end
      wr(A_CLAIM, 32'h3);
      checks++;
      if (irq_out !== 1'b1 || irq_id !== 5'd2) begin
         failures++; $display("FAIL level_bad_claim irq_out=%0b irq_id=%0d exp 1/2", irq_out, irq_id);
      end
      exp_q.push_back(32'h0);
      rd(A_CMPL, got); exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin failures++; $display("FAIL level_no_svc got=%h exp=%h", got, exp); end
      wr(A_CLAIM, 32'h2);
      wr(A_CLAIM, 32'h3);
      exp_q.push_back(32'h2);
      rd(A_CMPL, got); exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin failures++; $display("FAIL level_svc got=%h exp=%h", got, exp); end
      checks++;
      if (irq_out !== 1'b0) begin
         failures++; $display("FAIL level_svc_out irq_out=%0b exp 0", irq_out);
      end
      wr(A_CMPL, 32'h2);
      for (int n = 0; n < 8 && irq_out !== 1'b1; n++) tick();
      checks++;
      if (irq_out !== 1'b1 || irq_id !== 5'd2) begin
         failures++; $display("FAIL level_reassert irq_out=%0b irq_id=%0d exp 1/2", irq_out, irq_id);
      end
      wr(A_CLAIM, 32'h2);
      irq_src[1] = 1'b0; tick();
      wr(A_CMPL, 32'h2);
      for (int n = 0; n < 8 && irq_out !== 1'b1; n++) tick();
      checks++;
      if (irq_out !== 1'b1 || irq_id !== 5'd3) begin
         failures++; $display("FAIL level_next irq_out=%0b irq_id=%0d exp 1/3", irq_out, irq_id);
      end
      wr(A_CLAIM, 32'h3);
      irq_src = '0; tick();
      wr(A_CMPL, 32'h3);
      tick(); tick();
      checks++;
      if (irq_out !== 1'b0 || irq_id !== 5'd0) begin
         failures++; $display("FAIL level_idle irq_out=%0b irq_id=%0d exp 0/0", irq_out, irq_id);
      end
   endtask

   task automatic test_disable();
      logic [31:0] got, exp;
      wr(A_TYPE, 32'h1); wr(A_EN, 32'h1);
      irq_src[0] = 1'b1; tick();
      irq_src[0] = 1'b0; tick();
      wr(A_EN, 32'h0); tick();
      checks++;
      if (irq_out !== 1'b0 || irq_id !== 5'd0) begin
         failures++; $display("FAIL disable_drop irq_out=%0b irq_id=%0d exp 0/0", irq_out, irq_id);
      end
      exp_q.push_back(32'h1);
      rd(A_PEND, got); exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin failures++; $display("FAIL disable_pend got=%h exp=%h", got, exp); end
      wr(A_EN, 32'h1); tick();
      checks++;
      if (irq_out !== 1'b1 || irq_id !== 5'd1) begin
         failures++; $display("FAIL reenable irq_out=%0b irq_id=%0d exp 1/1", irq_out, irq_id);
      end
      wr(A_PEND, 32'h1);
      exp_q.push_back(32'h0);
      rd(A_PEND, got); exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin failures++; $display("FAIL w1c_pend got=%h exp=%h", got, exp); end
      tick();
      checks++;
      if (irq_out !== 1'b0 || irq_id !== 5'd0) begin
         failures++; $display("FAIL w1c_drop irq_out=%0b irq_id=%0d exp 0/0", irq_out, irq_id);
      end
   endtask

   task automatic test_service_accum_reset();
      logic [31:0] got, exp;
      logic [31:0] addrs [4];
      wr(A_TYPE, 32'h1); wr(A_EN, 32'h3);
      irq_src[1] = 1'b1;
      for (int n = 0; n < 8 && irq_out !== 1'b1; n++) tick();
      checks++;
      if (irq_out !== 1'b1 || irq_id !== 5'd2) begin
         failures++; $display("FAIL accum_req irq_out=%0b irq_id=%0d exp 1/2", irq_out, irq_id);
      end
      wr(A_CLAIM, 32'h2);
      irq_src[0] = 1'b1; tick();
      irq_src[0] = 1'b0; tick();
      exp_q.push_back(32'h1);
      rd(A_PEND, got); exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin failures++; $display("FAIL accum_pend got=%h exp=%h", got, exp); end
      checks++;
      if (irq_out !== 1'b0) begin
         failures++; $display("FAIL accum_quiet irq_out=%0b exp 0", irq_out);
      end
      wr(A_CMPL, 32'h2);
      for (int n = 0; n < 8 && irq_out !== 1'b1; n++) tick();
      checks++;
      if (irq_out !== 1'b1 || irq_id !== 5'd1) begin
         failures++; $display("FAIL accum_next irq_out=%0b irq_id=%0d exp 1/1", irq_out, irq_id);
      end
      rst = 1'b0; irq_src = '0; tick();
      checks++;
      if (irq_out !== 1'b0 || irq_id !== 5'd0) begin
         failures++; $display("FAIL midreset_out irq_out=%0b irq_id=%0d exp 0/0", irq_out, irq_id);
      end
      rst = 1'b1;
      addrs = '{A_PEND, A_EN, A_TYPE, A_CMPL};
      for (int k = 0; k < 4; k++) exp_q.push_back(32'h0);
      foreach (addrs[k]) begin
         rd(addrs[k], got);
         exp = exp_q.pop_front();
         checks++;
         if (got !== exp) begin
            failures++; $display("FAIL midreset_read addr=%h got=%h exp=%h", addrs[k], got, exp);
         end
      end
   endtask

   initial begin
      test_reset();
      test_edge_claim();
      test_level();
      test_disable();
      test_service_accum_reset();
      if (exp_q.size() != 0) begin
         failures++; $display("FAIL scoreboard_leftover entries=%0d exp 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule
